mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the data and address width of all ports.
REQ-002 The module SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles one access waits for mem_ready.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cpu_memread, cpu_memwrite  in  1 each  CPU controller access request, held until stall drops.
REQ-006 cpu_lock  in  1  CPU holds the grant across back-to-back accesses (FETCH1..FETCH3).
REQ-007 cpu_adr, cpu_wd  in  WIDTH each  CPU address and write data.
REQ-008 cpu_stall  out  1  CPU controller must hold its state.
REQ-009 cpu_rd  out  WIDTH  read data to the CPU.
REQ-010 host_req, host_we  in  1 each  host (program loader) request and write-enable, held until host_ack.
REQ-011 host_adr, host_wd  in  WIDTH each  host address and write data.
REQ-012 host_ack  out  1  one-cycle completion pulse.
REQ-013 host_rd  out  WIDTH  read data to the host.
REQ-014 mem_re, mem_we  out  1 each  memory read and write strobes.
REQ-015 mem_adr, mem_wd  out  WIDTH each  memory address and write data.
REQ-016 mem_rd  in  WIDTH  memory read data.
REQ-017 mem_ready  in  1  memory completes the current access this cycle.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, CPU_ACC and HOST_ACC; a registered last_grant bit (0=CPU, 1=HOST) and a wait counter of ceil(log2(TIMEOUT+1)) bits SHALL also be held.
REQ-020 IDLE SHALL go to CPU_ACC if a CPU request (memread|memwrite) exists and either host_req=0 or last_grant=HOST.
REQ-021 Otherwise IDLE SHALL go to HOST_ACC if host_req=1; with no requests it SHALL stay in IDLE.
REQ-022 In CPU_ACC the outputs SHALL be mem_adr=cpu_adr, mem_wd=cpu_wd, mem_re=cpu_memread and mem_we=cpu_memwrite.
REQ-023 In HOST_ACC the outputs SHALL be mem_adr=host_adr, mem_wd=host_wd, mem_re=~host_we and mem_we=host_we.
REQ-024 In IDLE the outputs SHALL be mem_re=mem_we=0 and mem_adr=mem_wd=0.
REQ-025 cpu_stall SHALL be combinational: 1 when a CPU request exists, unless state=CPU_ACC and (mem_ready=1 or the timeout fires) in the same cycle.
REQ-026 cpu_rd and host_rd SHALL equal mem_rd combinationally.
REQ-027 host_ack SHALL be 1 only in HOST_ACC in the cycle mem_ready=1 or the timeout fires.
REQ-028 On completion in CPU_ACC, last_grant SHALL become CPU.
REQ-029 On completion in CPU_ACC with cpu_lock=1, the state SHALL remain CPU_ACC with the counter cleared, and the host SHALL be ignored.
REQ-030 On completion in CPU_ACC with cpu_lock=0, the next state SHALL be IDLE.
REQ-031 On completion in HOST_ACC, last_grant SHALL become HOST and the next state SHALL be IDLE.
REQ-032 Each access SHALL cost at least 2 cycles (IDLE arbitration plus access); a locked sequence of N accesses with zero-wait memory SHALL cost N+1 cycles.
REQ-033 The wait counter SHALL clear on entry to an ACC state and increment each ACC cycle without mem_ready.
REQ-034 When the counter equals TIMEOUT without mem_ready, the access SHALL complete as if mem_ready=1, cpu_rd/host_rd SHALL read 0, and err SHALL set.
REQ-035 err SHALL stay set until reset.
REQ-036 A host_req drop mid-access SHALL NOT abort the access; it completes and host_ack still pulses.
REQ-037 A CPU request drop mid-access (protocol violation) SHALL cause a return to IDLE the next cycle with no ack.
REQ-038 With simultaneous requests and last_grant=CPU, the host SHALL win; grants SHALL alternate while both persist, except during lock.

Reset
REQ-039 Asserting reset (low) at any time, including mid-access, SHALL immediately force state=IDLE, last_grant=HOST, counter=0 and err=0, with all strobes and host_ack at 0.
REQ-040 After release, a pending CPU request SHALL win the first arbitration.

Verification
REQ-041 Locked 4-byte fetch: cpu_memread=1, cpu_lock=1 for 3 accesses, mem_ready=1 -> four back-to-back mem_re cycles after one IDLE cycle; host_req=1 throughout -> host_ack only after the 4th byte.
REQ-042 Contention: CPU and host requesting continuously, no lock -> grants alternate CPU, HOST, CPU, ...; each host_ack is a single cycle.
REQ-043 Host write: host_we=1, host_adr=8'h10, host_wd=8'hA5 -> mem_we=1, mem_adr=8'h10, mem_wd=8'hA5; host_ack pulses on mem_ready.
REQ-044 Wait states: mem_ready delayed 3 cycles -> cpu_stall=1 for 4 cycles and drops in the ready cycle; cpu_rd = mem_rd.
REQ-045 Timeout: mem_ready held 0 -> completion at counter=15, cpu_rd=8'h00, err=1 sticky.
REQ-046 Reset mid HOST_ACC -> strobes 0 asynchronously, no host_ack, first grant after release goes to the CPU.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: CPU controller vs. host loader, with CPU lock,
// round-robin on contention and a per-access ready timeout.
module mem_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_memread,
    input  logic             cpu_memwrite,
    input  logic             cpu_lock,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic             cpu_stall,
    output logic [WIDTH-1:0] cpu_rd,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [WIDTH-1:0] host_adr,
    input  logic [WIDTH-1:0] host_wd,
    output logic             host_ack,
    output logic [WIDTH-1:0] host_rd,
    output logic             mem_re,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    input  logic             mem_ready,
    output logic             err
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CPU_ACC, HOST_ACC} state_t;

    state_t        state, state_nxt;
    logic          last_grant, last_grant_nxt;   // 0 = CPU, 1 = HOST
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_nxt;
    logic          cpu_req, in_acc, tmo, done;

    assign cpu_req = cpu_memread | cpu_memwrite;
    assign in_acc  = (state == CPU_ACC) || (state == HOST_ACC);
    // A timed-out access completes as if memory had answered with zero data.
    assign tmo     = in_acc && !mem_ready && (cnt == CW'(TIMEOUT));
    assign done    = in_acc && (mem_ready || tmo);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        err_nxt        = err | tmo;
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        mem_adr        = '0;
        mem_wd         = '0;
        host_ack       = 1'b0;
        cpu_stall      = cpu_req;
        cpu_rd         = tmo ? '0 : mem_rd;
        host_rd        = tmo ? '0 : mem_rd;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (cpu_req && (!host_req || last_grant)) begin
                    state_nxt = CPU_ACC;
                end else if (host_req) begin
                    state_nxt = HOST_ACC;
                end
            end
            CPU_ACC: begin
                mem_adr = cpu_adr;
                mem_wd  = cpu_wd;
                mem_re  = cpu_memread;
                mem_we  = cpu_memwrite;
                if (!cpu_req) begin
                    // Request withdrawn mid-access: abandon without completion.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (done) begin
                    cpu_stall      = 1'b0;
                    last_grant_nxt = 1'b0;
                    cnt_nxt        = '0;
                    if (!cpu_lock) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HOST_ACC: begin
                mem_adr = host_adr;
                mem_wd  = host_wd;
                mem_re  = ~host_we;
                mem_we  = host_we;
                if (done) begin
                    host_ack       = 1'b1;
                    last_grant_nxt = 1'b1;
                    cnt_nxt        = '0;
                    state_nxt      = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table followed by
// hand-written timeout and mid-access reset sequences.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_memread, cpu_memwrite, cpu_lock;
    logic [7:0] cpu_adr, cpu_wd;
    logic       cpu_stall;
    logic [7:0] cpu_rd;
    logic       host_req, host_we;
    logic [7:0] host_adr, host_wd;
    logic       host_ack;
    logic [7:0] host_rd;
    logic       mem_re, mem_we;
    logic [7:0] mem_adr, mem_wd, mem_rd;
    logic       mem_ready;
    logic       err;

    int passed = 0;
    int total  = 0;

    mem_arbiter #(.WIDTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_lock(cpu_lock),
        .cpu_adr(cpu_adr), .cpu_wd(cpu_wd), .cpu_stall(cpu_stall), .cpu_rd(cpu_rd),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wd(host_wd),
        .host_ack(host_ack), .host_rd(host_rd),
        .mem_re(mem_re), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    // ctl = {rd, wr, lock, hreq, hwe, rdy}; ex = {stall, ack, re, we}
    typedef struct {
        logic [5:0] ctl;
        logic [7:0] cadr, hadr, hwd, mrd;
        logic [3:0] ex;
        logic [7:0] madr, mwd, crd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] ctl, input logic [7:0] cadr, hadr, hwd, mrd,
                                input logic [3:0] ex, input logic [7:0] madr, mwd, crd);
        vec_t v;
        v.ctl = ctl; v.cadr = cadr; v.hadr = hadr; v.hwd = hwd; v.mrd = mrd;
        v.ex = ex; v.madr = madr; v.mwd = mwd; v.crd = crd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %02h expected %02h", nm, idx, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_memread = 0; cpu_memwrite = 0; cpu_lock = 0; cpu_adr = 0;
        host_req = 0; host_we = 0; host_adr = 0; host_wd = 0;
        mem_rd = 0; mem_ready = 0;
    endtask

    initial begin
        cpu_wd = 8'h3C;
        idle_inputs();
        reset = 0;

        // Locked 4-byte fetch with host waiting
        vecs.push_back(mk(6'b101100, 8'h20, 8'h10, 8'h00, 8'h11, 4'b1000, 8'h00, 8'h00, 8'h11));
        vecs.push_back(mk(6'b101101, 8'h20, 8'h10, 8'h00, 8'hA1, 4'b0010, 8'h20, 8'h3C, 8'hA1));
        vecs.push_back(mk(6'b101101, 8'h21, 8'h10, 8'h00, 8'hA2, 4'b0010, 8'h21, 8'h3C, 8'hA2));
        vecs.push_back(mk(6'b101101, 8'h22, 8'h10, 8'h00, 8'hA3, 4'b0010, 8'h22, 8'h3C, 8'hA3));
        vecs.push_back(mk(6'b100101, 8'h23, 8'h10, 8'h00, 8'hA4, 4'b0010, 8'h23, 8'h3C, 8'hA4));
        vecs.push_back(mk(6'b000100, 8'h00, 8'h10, 8'h00, 8'h55, 4'b0000, 8'h00, 8'h00, 8'h55));
        vecs.push_back(mk(6'b000101, 8'h00, 8'h10, 8'h00, 8'hB6, 4'b0110, 8'h10, 8'h00, 8'hB6));
        // Host write with one wait state
        vecs.push_back(mk(6'b000110, 8'h00, 8'h10, 8'hA5, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(6'b000110, 8'h00, 8'h10, 8'hA5, 8'h00, 4'b0001, 8'h10, 8'hA5, 8'h00));
        vecs.push_back(mk(6'b000111, 8'h00, 8'h10, 8'hA5, 8'hE9, 4'b0101, 8'h10, 8'hA5, 8'hE9));
        vecs.push_back(mk(6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00));
        // Contention: CPU, HOST, CPU, HOST
        vecs.push_back(mk(6'b100100, 8'h30, 8'h40, 8'h00, 8'h01, 4'b1000, 8'h00, 8'h00, 8'h01));
        vecs.push_back(mk(6'b100101, 8'h30, 8'h40, 8'h00, 8'h02, 4'b0010, 8'h30, 8'h3C, 8'h02));
        vecs.push_back(mk(6'b100101, 8'h31, 8'h40, 8'h00, 8'h03, 4'b1000, 8'h00, 8'h00, 8'h03));
        vecs.push_back(mk(6'b100101, 8'h31, 8'h40, 8'h00, 8'h04, 4'b1110, 8'h40, 8'h00, 8'h04));
        vecs.push_back(mk(6'b100101, 8'h31, 8'h40, 8'h00, 8'h05, 4'b1000, 8'h00, 8'h00, 8'h05));
        vecs.push_back(mk(6'b100101, 8'h31, 8'h40, 8'h00, 8'h06, 4'b0010, 8'h31, 8'h3C, 8'h06));
        vecs.push_back(mk(6'b100111, 8'h32, 8'h41, 8'h5A, 8'h07, 4'b1000, 8'h00, 8'h00, 8'h07));
        vecs.push_back(mk(6'b100111, 8'h32, 8'h41, 8'h5A, 8'h08, 4'b1101, 8'h41, 8'h5A, 8'h08));
        vecs.push_back(mk(6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00));
        // CPU read with three wait states, then a CPU write
        vecs.push_back(mk(6'b100000, 8'h50, 8'h00, 8'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(6'b100000, 8'h50, 8'h00, 8'h00, 8'h01, 4'b1010, 8'h50, 8'h3C, 8'h01));
        vecs.push_back(mk(6'b100000, 8'h50, 8'h00, 8'h00, 8'h02, 4'b1010, 8'h50, 8'h3C, 8'h02));
        vecs.push_back(mk(6'b100000, 8'h50, 8'h00, 8'h00, 8'h03, 4'b1010, 8'h50, 8'h3C, 8'h03));
        vecs.push_back(mk(6'b100001, 8'h50, 8'h00, 8'h00, 8'hC4, 4'b0010, 8'h50, 8'h3C, 8'hC4));
        vecs.push_back(mk(6'b010000, 8'h60, 8'h00, 8'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(6'b010001, 8'h60, 8'h00, 8'h00, 8'h00, 4'b0001, 8'h60, 8'h3C, 8'h00));
        // CPU withdraws mid-access, then back in IDLE
        vecs.push_back(mk(6'b100000, 8'h70, 8'h00, 8'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(6'b100000, 8'h70, 8'h00, 8'h00, 8'h00, 4'b1010, 8'h70, 8'h3C, 8'h00));
        vecs.push_back(mk(6'b000000, 8'h70, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h70, 8'h3C, 8'h00));
        vecs.push_back(mk(6'b000001, 8'h77, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00));
        // Host drops its request mid-access; access still completes with ack
        vecs.push_back(mk(6'b000100, 8'h00, 8'h12, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00));
        vecs.push_back(mk(6'b000000, 8'h00, 8'h12, 8'h00, 8'h00, 4'b0010, 8'h12, 8'h00, 8'h00));
        vecs.push_back(mk(6'b000001, 8'h00, 8'h12, 8'h00, 8'hD3, 4'b0110, 8'h12, 8'h00, 8'hD3));
        vecs.push_back(mk(6'b000000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00));

        // Reset state
        #12;
        chk("rst_stall", 0, 8'(cpu_stall), 8'h00);
        chk("rst_ack",   0, 8'(host_ack), 8'h00);
        chk("rst_re",    0, 8'(mem_re), 8'h00);
        chk("rst_we",    0, 8'(mem_we), 8'h00);
        chk("rst_err",   0, 8'(err), 8'h00);
        @(negedge clk);
        reset = 1;

        foreach (vecs[i]) begin
            step();
            {cpu_memread, cpu_memwrite, cpu_lock, host_req, host_we, mem_ready} = vecs[i].ctl;
            cpu_adr = vecs[i].cadr; host_adr = vecs[i].hadr;
            host_wd = vecs[i].hwd;  mem_rd = vecs[i].mrd;
            #3;
            chk("stall",   i, 8'(cpu_stall), 8'(vecs[i].ex[3]));
            chk("ack",     i, 8'(host_ack), 8'(vecs[i].ex[2]));
            chk("re",      i, 8'(mem_re), 8'(vecs[i].ex[1]));
            chk("we",      i, 8'(mem_we), 8'(vecs[i].ex[0]));
            chk("adr",     i, mem_adr, vecs[i].madr);
            chk("wd",      i, mem_wd, vecs[i].mwd);
            chk("cpu_rd",  i, cpu_rd, vecs[i].crd);
            chk("host_rd", i, host_rd, vecs[i].crd);
            chk("err",     i, 8'(err), 8'h00);
        end

        // Timeout: mem_ready never arrives; completion in the 16th access cycle
        step();
        idle_inputs();
        cpu_memread = 1; cpu_adr = 8'h88; mem_rd = 8'hFF;
        #3;
        chk("to_idle_stall", 0, 8'(cpu_stall), 8'h01);
        for (int k = 0; k < 16; k++) begin
            step();
            #3;
            chk("to_re", k, 8'(mem_re), 8'h01);
            chk("to_stall", k, 8'(cpu_stall), (k == 15) ? 8'h00 : 8'h01);
            chk("to_cpu_rd", k, cpu_rd, (k == 15) ? 8'h00 : 8'hFF);
            chk("to_err", k, 8'(err), 8'h00);
        end
        step();
        cpu_memread = 0;
        #3;
        chk("to_err_set", 0, 8'(err), 8'h01);
        chk("to_back_idle", 0, mem_adr, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            #3;
            chk("to_err_sticky", k, 8'(err), 8'h01);
        end

        // Reset asserted asynchronously during a host read
        step();
        host_req = 1; host_adr = 8'h33; mem_rd = 8'h44;
        step();
        #3;
        chk("hr_re", 0, 8'(mem_re), 8'h01);
        chk("hr_adr", 0, mem_adr, 8'h33);
        chk("hr_ack", 0, 8'(host_ack), 8'h00);
        step();
        #1;
        reset = 0;
        #1;
        chk("ar_re", 0, 8'(mem_re), 8'h00);
        chk("ar_adr", 0, mem_adr, 8'h00);
        chk("ar_err", 0, 8'(err), 8'h00);
        cpu_memread = 1; cpu_adr = 8'h66; mem_ready = 1;
        #1;
        chk("ar_ack", 0, 8'(host_ack), 8'h00);
        step();
        chk("ar_ack", 1, 8'(host_ack), 8'h00);
        chk("ar_re", 1, 8'(mem_re), 8'h00);
        #1;
        reset = 1;
        #2;
        chk("post_idle_stall", 0, 8'(cpu_stall), 8'h01);
        chk("post_idle_re", 0, 8'(mem_re), 8'h00);
        step();
        #3;
        chk("post_cpu_re", 0, 8'(mem_re), 8'h01);
        chk("post_cpu_adr", 0, mem_adr, 8'h66);
        chk("post_cpu_ack", 0, 8'(host_ack), 8'h00);
        chk("post_cpu_stall", 0, 8'(cpu_stall), 8'h00);
        step();
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
